// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, fetch error codes and constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        FE_NONE     = 2'b00,
        FE_MISALIGN = 2'b01,
        FE_TIMEOUT  = 2'b10
    } fetch_err_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/fetch_timer.sv
// Loadable up-counter with clear and enable; flags expiry at TIMEOUT-1.
module fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       enable,
    output logic [7:0] count,
    output logic       expire
);

    logic [7:0] count_reg;

    // Counter register: clear has priority over load, load over enable.
    // The count saturates at the expiry value so it never wraps.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= 8'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (enable && !expire) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign count  = count_reg;
    assign expire = (count_reg == 8'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: fetches one word at the PC via req/ack, holds it
// in the IR for decode, provides PC+4, and reports misalign/timeout errors.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] IR_RESET = NOP_INSTR[DATA_W-1:0]
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_start,
    input  logic              ir_consume,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              ir_valid,
    output logic              fetch_busy,
    output logic [1:0]        fetch_err
);

    fetch_state_t      state_reg, state_next;
    logic              req_reg, req_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] pc4_reg, pc4_next;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic              valid_reg, valid_next;
    logic [1:0]        err_reg, err_next;

    logic              timer_clear;
    logic              timer_enable;
    logic              timer_expire;
    logic [7:0]        timer_count;
    logic              pc_aligned;

    assign pc_aligned = (pc_in[1:0] == 2'b00);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .load     (1'b0),
        .load_val (8'd0),
        .enable   (timer_enable),
        .count    (timer_count),
        .expire   (timer_expire)
    );

    // Next-state and next-output logic; a new fetch is launched from IDLE,
    // from ERR, or from DONE when decode consumes the IR in the same cycle.
    always_comb begin
        state_next   = state_reg;
        req_next     = req_reg;
        addr_next    = addr_reg;
        pc4_next     = pc4_reg;
        ir_next      = ir_reg;
        valid_next   = valid_reg;
        err_next     = err_reg;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;

        case (state_reg)
            REQ: begin
                if (imem_ack) begin
                    // Ack wins even when the timer expires in the same cycle.
                    ir_next    = imem_rdata;
                    req_next   = 1'b0;
                    valid_next = 1'b1;
                    state_next = DONE;
                end else if (timer_expire) begin
                    req_next   = 1'b0;
                    err_next   = FE_TIMEOUT;
                    state_next = ERR;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            DONE: begin
                if (ir_consume) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: ;
        endcase

        // Launch rules shared by IDLE, ERR and the DONE+consume case.
        if ((state_reg == IDLE) || (state_reg == ERR) ||
            ((state_reg == DONE) && ir_consume)) begin
            if (fetch_start) begin
                if (pc_aligned) begin
                    req_next    = 1'b1;
                    addr_next   = pc_in;
                    pc4_next    = pc_in + ADDR_W'(PC_INCR);
                    err_next    = FE_NONE;
                    timer_clear = 1'b1;
                    state_next  = REQ;
                end else begin
                    err_next   = FE_MISALIGN;
                    state_next = ERR;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            addr_reg  <= '0;
            pc4_reg   <= '0;
            ir_reg    <= IR_RESET;
            valid_reg <= 1'b0;
            err_reg   <= FE_NONE;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            addr_reg  <= addr_next;
            pc4_reg   <= pc4_next;
            ir_reg    <= ir_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    assign imem_req   = req_reg;
    assign imem_addr  = addr_reg;
    assign pc_plus4   = pc4_reg;
    assign ir_out     = ir_reg;
    assign ir_valid   = valid_reg;
    assign fetch_busy = req_reg;
    assign fetch_err  = err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (TIMEOUT=16).
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        fetch_start;
    logic        ir_consume;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir_out;
    logic [31:0] pc_plus4;
    logic        ir_valid;
    logic        fetch_busy;
    logic [1:0]  fetch_err;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (16),
        .IR_RESET (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .fetch_start (fetch_start),
        .ir_consume  (ir_consume),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir_out      (ir_out),
        .pc_plus4    (pc_plus4),
        .ir_valid    (ir_valid),
        .fetch_busy  (fetch_busy),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; pc_in = '0; fetch_start = 1'b0; ir_consume = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_addr",  imem_addr,           32'd0);
        chk("rst_ir",    ir_out,              32'h0000_0000);
        chk("rst_pc4",   pc_plus4,            32'd0);
        chk("rst_valid", {31'd0, ir_valid},   32'd0);
        chk("rst_busy",  {31'd0, fetch_busy}, 32'd0);
        chk("rst_err",   {30'd0, fetch_err},  32'd0);
        $display("txn reset done");

        // Normal fetch with zero wait states.
        pc_in = 32'h0000_0100; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("n_req",  {31'd0, imem_req},   32'd1);
        chk("n_busy", {31'd0, fetch_busy}, 32'd1);
        chk("n_addr", imem_addr,           32'h0000_0100);
        chk("n_pc4",  pc_plus4,            32'h0000_0104);
        imem_ack = 1'b1; imem_rdata = 32'h2002_0005;
        tick();
        imem_ack = 1'b0;
        chk("n_req_drop", {31'd0, imem_req}, 32'd0);
        chk("n_valid",    {31'd0, ir_valid}, 32'd1);
        chk("n_ir",       ir_out,            32'h2002_0005);
        tick();
        chk("n_valid_hold", {31'd0, ir_valid}, 32'd1);
        ir_consume = 1'b1;
        tick();
        ir_consume = 1'b0;
        chk("n_consume", {31'd0, ir_valid}, 32'd0);
        chk("n_ir_keep", ir_out,            32'h2002_0005);
        $display("txn normal fetch pc=00000100 ir=%h", ir_out);

        // Five wait states, PC changes during REQ.
        pc_in = 32'h0000_0100; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        pc_in = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("w_req",  {31'd0, imem_req}, 32'd1);
            chk("w_addr", imem_addr,         32'h0000_0100);
        end
        imem_ack = 1'b1; imem_rdata = 32'h8C41_0004;
        tick();
        imem_ack = 1'b0;
        chk("w_req_drop", {31'd0, imem_req}, 32'd0);
        chk("w_ir",       ir_out,            32'h8C41_0004);
        chk("w_pc4",      pc_plus4,          32'h0000_0104);
        // Stray ack in DONE must not change the IR.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("w_stray_ir", ir_out, 32'h8C41_0004);
        ir_consume = 1'b1;
        tick();
        ir_consume = 1'b0;
        $display("txn wait-state fetch ir=%h", ir_out);

        // Misaligned PC.
        pc_in = 32'h0000_0102; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("m_err", {30'd0, fetch_err}, 32'd1);
        chk("m_req", {31'd0, imem_req},  32'd0);
        tick();
        chk("m_err_hold", {30'd0, fetch_err}, 32'd1);
        chk("m_req_hold", {31'd0, imem_req},  32'd0);
        pc_in = 32'h0000_0104; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("m_clr_err", {30'd0, fetch_err}, 32'd0);
        chk("m_req_ok",  {31'd0, imem_req},  32'd1);
        chk("m_addr",    imem_addr,          32'h0000_0104);
        $display("txn misalign then recover addr=%h", imem_addr);

        // Timeout: 16 REQ cycles without ack.
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t_req", {31'd0, imem_req}, 32'd1);
        end
        tick();
        chk("t_err",  {30'd0, fetch_err}, 32'd2);
        chk("t_req0", {31'd0, imem_req},  32'd0);
        chk("t_ir",   ir_out,             32'h8C41_0004);
        $display("txn timeout err=%0d", fetch_err);

        // Ack arriving on the expiry cycle wins.
        pc_in = 32'h0000_0108; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("e_clr_err", {30'd0, fetch_err}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("e_req_last", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h3C01_1234;
        tick();
        imem_ack = 1'b0;
        chk("e_valid", {31'd0, ir_valid},  32'd1);
        chk("e_ir",    ir_out,             32'h3C01_1234);
        chk("e_err",   {30'd0, fetch_err}, 32'd0);
        $display("txn ack-at-expiry ir=%h", ir_out);

        // Back-to-back fetch from DONE with PC wrap.
        pc_in = 32'hFFFF_FFFC; fetch_start = 1'b1; ir_consume = 1'b1;
        tick();
        fetch_start = 1'b0; ir_consume = 1'b0;
        chk("b_valid0", {31'd0, ir_valid}, 32'd0);
        chk("b_req",    {31'd0, imem_req}, 32'd1);
        chk("b_addr",   imem_addr,         32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 1'b0;
        chk("b_valid1", {31'd0, ir_valid}, 32'd1);
        chk("b_ir",     ir_out,            32'h1111_2222);
        chk("b_pc4",    pc_plus4,          32'h0000_0000);
        $display("txn back-to-back wrap pc4=%h", pc_plus4);

        // Reset in the middle of a REQ.
        ir_consume = 1'b1;
        tick();
        ir_consume = 1'b0;
        pc_in = 32'h0000_0200; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("r_req1", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_req",   {31'd0, imem_req},   32'd0);
        chk("r_ir",    ir_out,              32'h0000_0000);
        chk("r_valid", {31'd0, ir_valid},   32'd0);
        chk("r_err",   {30'd0, fetch_err},  32'd0);
        chk("r_busy",  {31'd0, fetch_busy}, 32'd0);
        chk("r_pc4",   pc_plus4,            32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ack = 1'b0;
        chk("r_ack_ir",    ir_out,            32'h0000_0000);
        chk("r_ack_valid", {31'd0, ir_valid}, 32'd0);
        $display("txn reset mid-REQ ir=%h", ir_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage sitting directly downstream of the program-counter register.
- Consumes the PC value and fetches one 32-bit instruction from instruction memory using a req/ack handshake.
- Holds the instruction in an instruction register (IR) for decode, and produces PC+4 for the next-PC mux.
- A fetch-timeout counter and a misalignment check report errors to the control unit.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction width.
- TIMEOUT, 16, maximum cycles to wait for imem_ack before error (legal range 2..255).
- IR_RESET, 32'h0000_0000, IR value after reset (MIPS NOP).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; one clock; sampled on posedge clk.
- pc_in  in  ADDR_W  current PC from the PC register.
- fetch_start  in  1  control unit requests a fetch of pc_in.
- ir_consume  in  1  decode has taken the IR; releases the DONE state.
- imem_req  out  1  memory request, held until acknowledged.
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  DATA_W  instruction word, valid when imem_ack=1.
- ir_out  out  DATA_W  instruction register.
- pc_plus4  out  ADDR_W  latched PC + 4.
- ir_valid  out  1  ir_out holds a fresh instruction.
- fetch_busy  out  1  a fetch is in flight (REQ state).
- fetch_err  out  2  00 none, 01 misaligned, 10 timeout.

Behaviour:
- Reset state:
  - FSM = IDLE.
  - imem_req=0, imem_addr=0, ir_out=IR_RESET, pc_plus4=0, ir_valid=0, fetch_busy=0, fetch_err=00.
  - Timeout counter = 0.
- FSM states: IDLE, REQ, DONE, ERR. All outputs are registered.
- IDLE:
  - fetch_start=1 with pc_in[1:0]==00: latch pc_q=pc_in, imem_addr=pc_in, pc_plus4=pc_in+4 (mod 2^ADDR_W; 32'hFFFF_FFFC yields 0). Next cycle imem_req=1, fetch_busy=1, state REQ, counter=0.
  - fetch_start=1 with pc_in[1:0]!=00: go to ERR, fetch_err=01, no memory request issued.
- REQ:
  - imem_req stays 1 and imem_addr stays constant; later pc_in changes are ignored.
  - Each cycle without ack increments the counter.
  - imem_ack=1: capture imem_rdata into ir_out; next cycle imem_req=0, fetch_busy=0, ir_valid=1, state DONE.
  - Minimum latency: fetch_start at edge N, imem_req high after edge N, ack sampled at edge N+1, ir_valid high after edge N+2.
  - Counter reaches TIMEOUT-1 with no ack: go to ERR, fetch_err=10, imem_req=0.
  - Ack in the same cycle as timeout expiry: ack wins, normal capture.
  - fetch_start while in REQ is ignored.
- DONE:
  - ir_valid=1; ir_out and pc_plus4 are held.
  - ir_consume=1: ir_valid=0 next cycle, state IDLE.
  - ir_consume=1 and fetch_start=1 together: back-to-back fetch. Apply the IDLE rules to pc_in directly (go to REQ or ERR); ir_valid drops for at least one cycle.
  - fetch_start without ir_consume is ignored.
- ERR:
  - fetch_err holds its value.
  - fetch_start=1 clears the error and applies the IDLE rules to pc_in in the same edge.
  - ir_out keeps its last captured value.
- imem_ack outside REQ is ignored; ir_out is unchanged.
- reset asserted in any state, including mid-REQ, forces reset values at that edge; imem_req is 0 after the edge.
- ir_out keeps its last value outside DONE; only a captured ack changes it.

Decomposition:
- Shared cpu_pkg holds:
  - fetch FSM state enum (IDLE, REQ, DONE, ERR);
  - fetch_err codes (FE_NONE=2'b00, FE_MISALIGN=2'b01, FE_TIMEOUT=2'b10);
  - NOP constant 32'h0000_0000;
  - PC increment constant 4.
- One natural sub-module, fetch_timer: a loadable up-counter with clear, enable and expire flag, parameterised by TIMEOUT.

Test Plan:
- Normal fetch: reset, pc_in=32'h0000_0100, fetch_start 1 cycle, imem_ack at 1st REQ cycle with rdata=32'h2002_0005 -> imem_addr=32'h0000_0100, ir_out=32'h2002_0005, pc_plus4=32'h0000_0104, ir_valid high 2 cycles after fetch_start, held until ir_consume.
- Wait states + PC change: ack after 5 cycles, pc_in changed to 32'h0000_0200 during REQ -> imem_req high exactly 6 cycles, imem_addr stays 32'h0000_0100, pc_plus4=32'h0000_0104.
- Misalignment: pc_in=32'h0000_0102, fetch_start -> fetch_err=01, imem_req never asserted; then pc_in=32'h0000_0104 with fetch_start -> fetch_err=00, REQ entered.
- Timeout with TIMEOUT=16: no ack -> fetch_err=10 after 16 REQ cycles, imem_req=0, ir_out unchanged. Repeat with ack on the expiry cycle -> capture, fetch_err=00.
- Back-to-back and wrap: in DONE, assert ir_consume and fetch_start together with pc_in=32'hFFFF_FFFC -> next state REQ, imem_addr=32'hFFFF_FFFC, pc_plus4=32'h0000_0000 after capture.
- Reset mid-operation: reset during REQ -> at that edge imem_req=0, ir_out=IR_RESET, ir_valid=0, fetch_err=00; a later imem_ack is ignored.
